// File: rtl/pc_next_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_next_unit_if
// Brief   : Bundle between control/CSR logic and the PC / next-PC unit.
// Rev     : 1.0  initial release
// ============================================================================
interface pc_next_unit_if #(
    parameter int XLEN = 32
);
    logic            STALL;
    logic [2:0]      PC_SEL;
    logic [XLEN-1:0] JALR;
    logic [XLEN-1:0] BRANCH;
    logic [XLEN-1:0] JAL;
    logic [XLEN-1:0] MTVEC;
    logic [XLEN-1:0] MEPC;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PC_PLUS4;
    logic            PEND;
    logic            MISALIGN;
    logic [XLEN-1:0] BAD_ADDR;

    modport master (
        output STALL, PC_SEL, JALR, BRANCH, JAL, MTVEC, MEPC,
        input  PC, PC_PLUS4, PEND, MISALIGN, BAD_ADDR
    );

    modport slave (
        input  STALL, PC_SEL, JALR, BRANCH, JAL, MTVEC, MEPC,
        output PC, PC_PLUS4, PEND, MISALIGN, BAD_ADDR
    );
endinterface
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_next_unit
// Brief   : PC register with next-PC select, stall-time redirect buffering,
//           trap priority and misaligned jump/branch target rejection.
// Rev     : 1.0  initial release
// ============================================================================
module pc_next_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter bit              ALIGN_CHECK = 1'b1
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    pc_next_unit_if.slave bus
);

    localparam logic [2:0] c_SEL_PC4    = 3'b000;
    localparam logic [2:0] c_SEL_JALR   = 3'b001;
    localparam logic [2:0] c_SEL_BRANCH = 3'b010;
    localparam logic [2:0] c_SEL_JAL    = 3'b011;
    localparam logic [2:0] c_SEL_MTVEC  = 3'b100;
    localparam logic [2:0] c_SEL_MEPC   = 3'b101;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HELD = 1'b1;

    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    logic [0:0]      r_state;
    logic [2:0]      r_psel;
    logic [XLEN-1:0] r_ptgt;
    logic [XLEN-1:0] r_pc;
    logic            r_mis;
    logic [XLEN-1:0] r_bad;

    logic [XLEN-1:0] w_new_tgt;
    logic            w_is_redir;
    logic            w_trap_locked;
    logic            w_take_new;
    logic [2:0]      w_eff_sel;
    logic [XLEN-1:0] w_eff_tgt;
    logic            w_eff_is_jump;
    logic            w_misalign;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;

    // Trap vectors are word aligned by construction; jump targets are taken raw
    // so the alignment check sees what the datapath actually produced.
    always_comb begin
        w_new_tgt = r_pc;
        case (bus.PC_SEL)
            c_SEL_JALR:   w_new_tgt = bus.JALR;
            c_SEL_BRANCH: w_new_tgt = bus.BRANCH;
            c_SEL_JAL:    w_new_tgt = bus.JAL;
            c_SEL_MTVEC:  w_new_tgt = {bus.MTVEC[XLEN-1:2], 2'b00};
            c_SEL_MEPC:   w_new_tgt = {bus.MEPC[XLEN-1:2], 2'b00};
            default:      w_new_tgt = r_pc;
        endcase
    end

    assign w_is_redir    = (bus.PC_SEL >= c_SEL_JALR) && (bus.PC_SEL <= c_SEL_MEPC);
    assign w_trap_locked = (r_state == c_ST_HELD) && (r_psel == c_SEL_MTVEC)
                           && (bus.PC_SEL != c_SEL_MTVEC);
    assign w_take_new    = w_is_redir && !w_trap_locked;

    always_comb begin
        w_eff_sel = bus.PC_SEL;
        w_eff_tgt = w_new_tgt;
        if (!w_take_new && (r_state == c_ST_HELD)) begin
            w_eff_sel = r_psel;
            w_eff_tgt = r_ptgt;
        end
    end

    assign w_eff_is_jump = (w_eff_sel == c_SEL_JALR) || (w_eff_sel == c_SEL_BRANCH)
                           || (w_eff_sel == c_SEL_JAL);
    assign w_misalign    = ALIGN_CHECK && w_eff_is_jump && (w_eff_tgt[1:0] != 2'b00);
    assign w_pc_plus4    = r_pc + c_FOUR;

    always_comb begin
        w_pc_next = r_pc;
        if (!w_misalign) begin
            case (w_eff_sel)
                c_SEL_PC4:    w_pc_next = w_pc_plus4;
                c_SEL_JALR,
                c_SEL_BRANCH,
                c_SEL_JAL,
                c_SEL_MTVEC,
                c_SEL_MEPC:   w_pc_next = w_eff_tgt;
                default:      w_pc_next = r_pc;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
            r_psel  <= c_SEL_PC4;
            r_ptgt  <= '0;
            r_pc    <= RESET_VEC;
            r_mis   <= 1'b0;
            r_bad   <= '0;
        end else if (bus.STALL) begin
            r_mis <= 1'b0;
            if (w_take_new) begin
                r_state <= c_ST_HELD;
                r_psel  <= bus.PC_SEL;
                r_ptgt  <= w_new_tgt;
            end
        end else begin
            // Slot is consumed or discarded on every unstalled edge.
            r_state <= c_ST_IDLE;
            r_pc    <= w_pc_next;
            r_mis   <= w_misalign;
            if (w_misalign) begin
                r_bad <= w_eff_tgt;
            end
        end
    end

    assign bus.PC       = r_pc;
    assign bus.PC_PLUS4 = w_pc_plus4;
    assign bus.PEND     = (r_state == c_ST_HELD);
    assign bus.MISALIGN = r_mis;
    assign bus.BAD_ADDR = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_next_unit
// Brief   : Directed bench for pc_next_unit, alignment check on (A) and off (B).
// Rev     : 1.0  initial release
// ============================================================================
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  sel;
    logic [31:0] jalr, br, jal, mtv, mepc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_next_unit_if #(.XLEN(32)) ifa ();
    pc_next_unit_if #(.XLEN(32)) ifb ();

    assign ifa.STALL = stall;  assign ifb.STALL = stall;
    assign ifa.PC_SEL = sel;   assign ifb.PC_SEL = sel;
    assign ifa.JALR = jalr;    assign ifb.JALR = jalr;
    assign ifa.BRANCH = br;    assign ifb.BRANCH = br;
    assign ifa.JAL = jal;      assign ifb.JAL = jal;
    assign ifa.MTVEC = mtv;    assign ifb.MTVEC = mtv;
    assign ifa.MEPC = mepc;    assign ifb.MEPC = mepc;

    pc_next_unit #(.XLEN(32), .RESET_VEC(32'h100), .ALIGN_CHECK(1'b1)) dut_a (
        .CLK(clk), .RST(rst), .bus(ifa.slave));
    pc_next_unit #(.XLEN(32), .RESET_VEC(32'h100), .ALIGN_CHECK(1'b0)) dut_b (
        .CLK(clk), .RST(rst), .bus(ifb.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 checks alignment, index 1 does not.
    logic [31:0] m_pc[2], m_ptgt[2], m_bad[2];
    logic [2:0]  m_psel[2];
    bit          m_pend[2], m_mis[2];
    bit          m_valid = 1'b0;

    function automatic bit is_redirect(input logic [2:0] s);
        return (s >= 3'd1) && (s <= 3'd5);
    endfunction

    function automatic logic [31:0] target_of(input logic [2:0] s);
        case (s)
            3'd1: return jalr;
            3'd2: return br;
            3'd3: return jal;
            3'd4: return mtv & 32'hFFFF_FFFC;
            3'd5: return mepc & 32'hFFFF_FFFC;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input int i);
        bit          align;
        bit          new_wins;
        logic [2:0]  es;
        logic [31:0] et;
        align    = (i == 0);
        new_wins = is_redirect(sel) && !(m_pend[i] && m_psel[i] == 3'd4 && sel != 3'd4);
        if (rst) begin
            m_pc[i] = 32'h100; m_pend[i] = 0; m_psel[i] = 0; m_ptgt[i] = 0;
            m_mis[i] = 0; m_bad[i] = 0;
        end else if (stall) begin
            m_mis[i] = 0;
            if (new_wins) begin
                m_pend[i] = 1; m_psel[i] = sel; m_ptgt[i] = target_of(sel);
            end
        end else begin
            if (new_wins)        begin es = sel;       et = target_of(sel); end
            else if (m_pend[i])  begin es = m_psel[i]; et = m_ptgt[i];      end
            else                 begin es = sel;       et = 32'h0;          end
            m_pend[i] = 0;
            if (align && es >= 3'd1 && es <= 3'd3 && et[1:0] != 2'b00) begin
                m_mis[i] = 1; m_bad[i] = et;
            end else begin
                m_mis[i] = 0;
                if (es == 3'd0)      m_pc[i] = m_pc[i] + 32'd4;
                else if (es <= 3'd5) m_pc[i] = et;
            end
        end
    endtask

    task automatic cmp_dut(input string tag, input int i, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic pend, input logic mis,
                           input logic [31:0] bad);
        check({tag, ".PC"}, pc, m_pc[i]);
        check({tag, ".PC_PLUS4"}, pc4, m_pc[i] + 32'd4);
        check({tag, ".PEND"}, {31'b0, pend}, {31'b0, m_pend[i]});
        check({tag, ".MISALIGN"}, {31'b0, mis}, {31'b0, m_mis[i]});
        if (m_mis[i]) check({tag, ".BAD_ADDR"}, bad, m_bad[i]);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        if (rst) m_valid = 1'b1;
        #1;
        if (m_valid) begin
            cmp_dut("A", 0, ifa.PC, ifa.PC_PLUS4, ifa.PEND, ifa.MISALIGN, ifa.BAD_ADDR);
            cmp_dut("B", 1, ifb.PC, ifb.PC_PLUS4, ifb.PEND, ifb.MISALIGN, ifb.BAD_ADDR);
        end
    end

    task automatic step(input logic s, input logic [2:0] ps);
        stall = s;
        sel   = ps;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; sel = 3'd0;
        jalr = 0; br = 0; jal = 0; mtv = 0; mepc = 0;
        @(negedge clk);
        rst = 1'b0;
        check("reset_pc", ifa.PC, 32'h100);
        check("reset_pend", {31'b0, ifa.PEND}, 32'h0);
        check("reset_bad", ifa.BAD_ADDR, 32'h0);

        step(0, 3'd0); check("seq1", ifa.PC, 32'h104);
        step(0, 3'd0); check("seq2", ifa.PC, 32'h108);
        step(0, 3'd0); check("seq3", ifa.PC, 32'h10C);

        jal = 32'h200; step(0, 3'd3); check("jal_200", ifa.PC, 32'h200);
        jal = 32'h400; step(1, 3'd3); check("stall_pend", {31'b0, ifa.PEND}, 32'h1);
        jal = 32'h0;   step(1, 3'd0); check("stall_hold", ifa.PC, 32'h200);
        step(1, 3'd0); check("stall_hold3", ifa.PC, 32'h200);
        step(0, 3'd0); check("buffered_jal", ifa.PC, 32'h400);
        check("pend_clear", {31'b0, ifa.PEND}, 32'h0);

        mtv = 32'h803;  step(1, 3'd4);
        jalr = 32'h500; step(1, 3'd1);
        br = 32'h600;   step(0, 3'd2); check("trap_priority", ifa.PC, 32'h800);

        mtv = 32'h900;  step(1, 3'd4);
        mtv = 32'hA01;  step(1, 3'd4);
        step(0, 3'd0);  check("mtvec_overwrite", ifa.PC, 32'hA00);

        jal = 32'h40;     step(0, 3'd3); check("jal_40", ifa.PC, 32'h40);
        jalr = 32'h1002;  step(0, 3'd1);
        check("mis_pc_hold", ifa.PC, 32'h40);
        check("mis_pulse", {31'b0, ifa.MISALIGN}, 32'h1);
        check("mis_bad", ifa.BAD_ADDR, 32'h1002);
        check("noalign_pc", ifb.PC, 32'h1002);
        check("noalign_nopulse", {31'b0, ifb.MISALIGN}, 32'h0);
        step(0, 3'd0);
        check("mis_deassert", {31'b0, ifa.MISALIGN}, 32'h0);
        check("bad_hold", ifa.BAD_ADDR, 32'h1002);
        check("after_mis_pc", ifa.PC, 32'h44);

        br = 32'h2001; step(1, 3'd2);
        check("no_mis_in_stall", {31'b0, ifa.MISALIGN}, 32'h0);
        step(0, 3'd0);
        check("buffered_mis", {31'b0, ifa.MISALIGN}, 32'h1);
        check("buffered_mis_bad", ifa.BAD_ADDR, 32'h2001);
        check("buffered_mis_pc", ifa.PC, 32'h44);

        jal = 32'hFFFF_FFFC; step(0, 3'd3); check("pc4_wrap", ifa.PC_PLUS4, 32'h0);
        step(0, 3'd0); check("wrap", ifa.PC, 32'h0);
        step(0, 3'd6); check("invalid_hold", ifa.PC, 32'h0);
        step(0, 3'd7); check("invalid_hold7", ifa.PC, 32'h0);

        mepc = 32'h300; step(1, 3'd5); check("mepc_pend", {31'b0, ifa.PEND}, 32'h1);
        rst = 1'b1; step(1, 3'd0); rst = 1'b0;
        check("rst_mid_pc", ifa.PC, 32'h100);
        check("rst_mid_pend", {31'b0, ifa.PEND}, 32'h0);
        step(0, 3'd0); check("rst_mid_adv", ifa.PC, 32'h104);
        step(0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
